// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the RV32I multi-cycle controller
// Opcodes and imm formats live here so the immediate generator and decoder agree.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_R, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JALR, CL_LUI, CL_JAL
  } op_class_t;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_SB   = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_UJ   = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] PCSRC_PC4   = 2'd0;
  localparam logic [1:0] PCSRC_PCIMM = 2'd1;
  localparam logic [1:0] PCSRC_ALU   = 2'd2;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;
  localparam logic [1:0] WBSEL_IMM = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Register-register ops and branches compare rs1 against rs2; everything else uses the immediate.
  function automatic logic class_uses_imm(input op_class_t c);
    return !(c == CL_R || c == CL_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_opdec.sv
// rtl/multicycle_ctrl_opdec.sv - combinational opcode classifier
// Maps Instruction[6:0] to an op class, immediate format and legality flag.
module ctrl_opdec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] imm_sel,
  output logic       legal
);

  always_comb begin
    op_class = CL_R;
    imm_sel  = IMM_NONE;
    legal    = 1'b1;
    case (opcode)
      OP_R:      begin op_class = CL_R;      imm_sel = IMM_NONE; end
      OP_IALU:   begin op_class = CL_IALU;   imm_sel = IMM_I;    end
      OP_LOAD:   begin op_class = CL_LOAD;   imm_sel = IMM_I;    end
      OP_STORE:  begin op_class = CL_STORE;  imm_sel = IMM_S;    end
      OP_BRANCH: begin op_class = CL_BRANCH; imm_sel = IMM_SB;   end
      OP_JALR:   begin op_class = CL_JALR;   imm_sel = IMM_I;    end
      OP_LUI:    begin op_class = CL_LUI;    imm_sel = IMM_U;    end
      OP_JAL:    begin op_class = CL_JAL;    imm_sel = IMM_UJ;   end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM with req/ack watchdog
// Sequences fetch/decode/exec/mem/wb and traps on illegal opcodes or missing acks.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_we,
  output logic [2:0] imm_sel,
  output logic       alu_src,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT);

  state_t    state, state_n;
  op_class_t cls_q, dec_class;
  logic [2:0] imm_q, dec_imm;
  logic       dec_legal;
  logic [1:0] cause_q, cause_n;
  logic [CW-1:0] wd_cnt;
  logic       wd_expired;
  logic       live;

  ctrl_opdec u_opdec (
    .opcode   (opcode),
    .op_class (dec_class),
    .imm_sel  (dec_imm),
    .legal    (dec_legal)
  );

  assign wd_expired = (ACK_TIMEOUT != 0) && (wd_cnt == LIMIT);
  // Reset wins over any ack arriving in the same cycle, so every strobe is gated by it.
  assign live       = !rst;
  assign trap_cause = cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_BOOT;
      cls_q   <= CL_R;
      imm_q   <= IMM_NONE;
      cause_q <= CAUSE_NONE;
      wd_cnt  <= '0;
    end else begin
      state   <= state_n;
      cause_q <= cause_n;
      if (state == S_DECODE) begin
        cls_q <= dec_class;
        imm_q <= dec_imm;
      end
      if (state_n != state)
        wd_cnt <= '0;
      else if ((ACK_TIMEOUT != 0) && (state == S_FETCH || state == S_MEM))
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    cause_n  = cause_q;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    imm_sel  = IMM_NONE;
    alu_src  = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PCSRC_PC4;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    wb_sel   = WBSEL_ALU;
    retire   = 1'b0;
    trap     = 1'b0;

    case (state)
      S_BOOT: state_n = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = live;
          state_n = S_DECODE;
        end else if (wd_expired) begin
          state_n = S_TRAP;
          cause_n = CAUSE_IMEM_TO;
        end
      end

      S_DECODE: begin
        imm_sel = dec_imm;
        alu_src = dec_legal && class_uses_imm(dec_class);
        if (dec_legal) begin
          state_n = S_EXEC;
        end else begin
          state_n = S_TRAP;
          cause_n = CAUSE_ILLEGAL;
        end
      end

      S_EXEC: begin
        imm_sel = imm_q;
        alu_src = class_uses_imm(cls_q);
        case (cls_q)
          CL_BRANCH: begin
            pc_we   = live;
            pc_src  = br_taken ? PCSRC_PCIMM : PCSRC_PC4;
            retire  = live;
            state_n = S_FETCH;
          end
          CL_LOAD, CL_STORE: state_n = S_MEM;
          default:           state_n = S_WB;
        endcase
      end

      S_MEM: begin
        imm_sel  = imm_q;
        alu_src  = class_uses_imm(cls_q);
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_STORE);
        if (dmem_ack) begin
          if (cls_q == CL_STORE) begin
            pc_we   = live;
            retire  = live;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end else if (wd_expired) begin
          state_n = S_TRAP;
          cause_n = CAUSE_DMEM_TO;
        end
      end

      S_WB: begin
        imm_sel = imm_q;
        alu_src = class_uses_imm(cls_q);
        reg_we  = live;
        pc_we   = live;
        retire  = live;
        state_n = S_FETCH;
        case (cls_q)
          CL_LOAD: wb_sel = WBSEL_MEM;
          CL_LUI:  wb_sel = WBSEL_IMM;
          CL_JAL:  begin wb_sel = WBSEL_PC4; pc_src = PCSRC_PCIMM; end
          CL_JALR: begin wb_sel = WBSEL_PC4; pc_src = PCSRC_ALU;   end
          default: wb_sel = WBSEL_ALU;
        endcase
      end

      S_TRAP: trap = 1'b1;

      default: state_n = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
// Directed and randomized instruction streams against a per-instruction outcome model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       br_taken = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, ir_we, alu_src, pc_we, dmem_req, dmem_we, reg_we, retire, trap;
  logic [2:0] imm_sel;
  logic [1:0] pc_src, wb_sel, trap_cause;

  int errors = 0;
  int checks = 0;

  // Per-class outcome tables, class order: R, I-ALU, LOAD, STORE, BRANCH, JALR, LUI, JAL
  int imm_t[8]   = '{7, 0, 0, 1, 2, 0, 3, 4};
  int alu_t[8]   = '{0, 1, 1, 1, 0, 1, 1, 1};
  int regwe_t[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
  int wbsel_t[8] = '{0, 0, 1, 0, 0, 2, 3, 2};
  int pcsrc_t[8] = '{0, 0, 0, 0, 0, 2, 0, 1};
  logic [6:0] ops[8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                         7'b1100011, 7'b1100111, 7'b0110111, 7'b1101111};

  multicycle_ctrl #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .imm_sel(imm_sel), .alu_src(alu_src), .pc_we(pc_we), .pc_src(pc_src),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ia, input logic da, input logic br, input logic r);
    @(posedge clk);
    #1;
    imem_ack = ia;
    dmem_ack = da;
    br_taken = br;
    rst      = r;
    @(negedge clk);
  endtask

  function automatic int class_of(input logic [6:0] op);
    for (int i = 0; i < 8; i++)
      if (ops[i] == op) return i;
    return -1;
  endfunction

  // Leaves the DUT in BOOT with rst low; the next step is the first FETCH cycle.
  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_instr(input logic [6:0] op, input int w1, input int w2,
                           input logic br, input string nm);
    int c, mem, st, exp_ret, exp_pcsrc;
    int retire_at, imem_cnt, irwe_cnt, dreq_cnt, dwe_bad, rwe_cnt, pwe_cnt;
    int imm_dec, alu_dec, ps, ws, imm_ret, trap_ret;
    logic ia, da;
    c   = class_of(op);
    mem = (c == 2 || c == 3) ? 1 : 0;
    st  = (c == 3) ? 1 : 0;
    case (c)
      4:       exp_ret = w1 + 2;
      3:       exp_ret = w1 + 3 + w2;
      2:       exp_ret = w1 + 4 + w2;
      default: exp_ret = w1 + 3;
    endcase
    exp_pcsrc = (c == 4) ? int'(br) : pcsrc_t[c];
    retire_at = -1; imem_cnt = 0; irwe_cnt = 0; dreq_cnt = 0; dwe_bad = 0;
    rwe_cnt = 0; pwe_cnt = 0; imm_dec = -1; alu_dec = -1; ps = -1; ws = -1;
    imm_ret = -1; trap_ret = -1;
    opcode = op;
    for (int k = 0; k < 40 && retire_at < 0; k++) begin
      ia = (k == w1) ? 1'b1 : (k > w1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mem == 1)
        da = (k == w1 + 3 + w2) ? 1'b1 : (k < w1 + 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      else
        da = 1'($urandom_range(0, 1));
      step(ia, da, br, 1'b0);
      if (imem_req) imem_cnt++;
      if (ir_we) irwe_cnt++;
      if (dmem_req) begin
        dreq_cnt++;
        if (dmem_we !== 1'(st)) dwe_bad++;
      end
      if (reg_we) rwe_cnt++;
      if (pc_we) pwe_cnt++;
      if (k == w1 + 1) begin
        imm_dec = int'(imm_sel);
        alu_dec = int'(alu_src);
      end
      if (retire) begin
        retire_at = k;
        ps = int'(pc_src);
        ws = int'(wb_sel);
        imm_ret = int'(imm_sel);
        trap_ret = int'(trap);
      end
    end
    chk({nm, ".retire_cycle"}, retire_at, exp_ret);
    chk({nm, ".imem_req_cycles"}, imem_cnt, w1 + 1);
    chk({nm, ".ir_we_count"}, irwe_cnt, 1);
    chk({nm, ".dmem_req_cycles"}, dreq_cnt, mem * (w2 + 1));
    chk({nm, ".dmem_we_bad"}, dwe_bad, 0);
    chk({nm, ".decode_imm_sel"}, imm_dec, imm_t[c]);
    chk({nm, ".decode_alu_src"}, alu_dec, alu_t[c]);
    chk({nm, ".retire_imm_sel"}, imm_ret, imm_t[c]);
    chk({nm, ".pc_src"}, ps, exp_pcsrc);
    chk({nm, ".pc_we_count"}, pwe_cnt, 1);
    chk({nm, ".reg_we_count"}, rwe_cnt, regwe_t[c]);
    if (regwe_t[c] == 1) chk({nm, ".wb_sel"}, ws, wbsel_t[c]);
    chk({nm, ".trap"}, trap_ret, 0);
  endtask

  initial begin
    int cnt, at;
    int idx;

    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst.imem_req", int'(imem_req), 0);
    chk("rst.ir_we", int'(ir_we), 0);
    chk("rst.dmem_req", int'(dmem_req), 0);
    chk("rst.retire", int'(retire), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("boot.imem_req", int'(imem_req), 0);
    chk("boot.imm_sel", int'(imm_sel), 7);
    chk("boot.trap", int'(trap), 0);
    chk("boot.trap_cause", int'(trap_cause), 0);
    chk("boot.pc_we", int'(pc_we), 0);

    run_instr(7'h13, 0, 0, 1'b0, "addi");
    run_instr(7'b0000011, 0, 3, 1'b0, "lw_wait3");
    run_instr(7'b1100011, 1, 0, 1'b1, "beq_taken");
    run_instr(7'b1100011, 0, 0, 1'b0, "beq_not_taken");
    run_instr(7'b1101111, 2, 0, 1'b0, "jal");
    run_instr(7'b1100111, 0, 0, 1'b0, "jalr");
    run_instr(7'b0110111, 0, 0, 1'b0, "lui");
    run_instr(7'b0100011, 0, 2, 1'b0, "sw");
    run_instr(7'b0110011, 1, 0, 1'b0, "r_type");
    run_instr(7'b0000011, 4, 4, 1'b0, "lw_ack_at_limit");

    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 7);
      run_instr(ops[idx], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    // Reset coinciding with imem_ack must not load the IR
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_fetch.ir_we", int'(ir_we), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_fetch.boot_imem_req", int'(imem_req), 0);

    opcode = 7'b1111111;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("illegal.decode_imm_sel", int'(imm_sel), 7);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("illegal.trap", int'(trap), 1);
    chk("illegal.trap_cause", int'(trap_cause), 1);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      cnt += int'(imem_req) + int'(pc_we) + int'(retire) + int'(reg_we) + int'(dmem_req);
    end
    chk("illegal.strobes_in_trap", cnt, 0);
    chk("illegal.trap_held", int'(trap), 1);
    chk("illegal.cause_held", int'(trap_cause), 1);
    do_reset();
    chk("illegal.cleared_trap", int'(trap), 0);
    chk("illegal.cleared_cause", int'(trap_cause), 0);

    cnt = 0; at = -1;
    for (int k = 0; k < 12 && at < 0; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (trap) at = k;
      else if (imem_req) cnt++;
    end
    chk("imem_to.trap_cycle", at, 5);
    chk("imem_to.req_cycles", cnt, 5);
    chk("imem_to.cause", int'(trap_cause), 2);
    do_reset();

    opcode = 7'b0000011;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    cnt = 0; at = -1;
    for (int k = 0; k < 12 && at < 0; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (trap) at = k;
      else if (dmem_req) cnt++;
    end
    chk("dmem_to.trap_cycle", at, 5);
    chk("dmem_to.req_cycles", cnt, 5);
    chk("dmem_to.cause", int'(trap_cause), 3);
    do_reset();

    opcode = 7'b0100011;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_mem.dmem_req_before", int'(dmem_req), 1);
    chk("rst_mem.retire", int'(retire), 0);
    chk("rst_mem.pc_we", int'(pc_we), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mem.dmem_req_after", int'(dmem_req), 0);
    chk("rst_mem.retire_after", int'(retire), 0);
    chk("rst_mem.boot_imm_sel", int'(imm_sel), 7);

    run_instr(7'h13, 1, 0, 1'b0, "addi_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
